// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: key codes,
// ALU op_sel encoding, FSM state enum and key classification helpers.
package calc_pkg;

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES} state_e;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_DIV = 4'hD;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= K_ADD) && (k <= K_DIV);
  endfunction

  // Operator keys are contiguous starting at ADD, so the offset is the encoding.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] t;
    t = k - K_ADD;
    return t[1:0];
  endfunction

endpackage

// File: rtl/key_event_qual.sv
// Debounce / one-shot qualifier for the keypad scanner.
// A key event is emitted once when btn_pressed holds an unchanged btn_out
// for STABLE_CYC cycles; the qualifier then needs btn_pressed=0 for
// STABLE_CYC cycles before it can emit again. Reset leaves it disarmed so a
// key held across reset is never taken as a new press.
// Ports: clk, reset (sync, active high), btn_pressed, btn_out[3:0] in;
//        key_evt (1-cycle pulse), key_code[3:0] out (valid with key_evt).
module key_event_qual #(
  parameter int STABLE_CYC = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pressed,
  input  logic [3:0] btn_out,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STB = CW'(STABLE_CYC);

  logic          prs_q, prs_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;   // length of the current unchanged run, saturating
  logic          armed_q, armed_d;
  logic          evt_q, evt_d;
  logic [3:0]    evt_code_q, evt_code_d;
  logic          same;

  always_comb begin
    same       = (btn_pressed == prs_q) && (!btn_pressed || (btn_out == code_q));
    prs_d      = btn_pressed;
    code_d     = btn_out;
    armed_d    = armed_q;
    evt_d      = 1'b0;
    evt_code_d = evt_code_q;
    if (!same)           cnt_d = CW'(1);
    else if (cnt_q == STB) cnt_d = STB;
    else                 cnt_d = cnt_q + CW'(1);

    if (armed_q && btn_pressed && (cnt_d == STB)) begin
      evt_d      = 1'b1;
      evt_code_d = btn_out;
      armed_d    = 1'b0;
    end else if (!armed_q && !btn_pressed && (cnt_d == STB)) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prs_q      <= 1'b0;
      code_q     <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      evt_q      <= 1'b0;
      evt_code_q <= '0;
    end else begin
      prs_q      <= prs_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      evt_q      <= evt_d;
      evt_code_q <= evt_code_d;
    end
  end

  assign key_evt  = evt_q;
  assign key_code = evt_code_q;

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator entry sequencer: turns qualified key events into decimal
// operands, hands them to the ALU over a start/done handshake and selects
// the displayed value.
// Ports: clk, reset (sync, active high), btn_pressed, btn_out[3:0] from the
//        scanner; alu_start, op_a[W], op_b[W], op_sel[2] to the ALU;
//        alu_done, alu_result[W] from the ALU; disp_value[W], busy out.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4,
  parameter int STABLE_CYC = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_pressed,
  input  logic [3:0]   btn_out,
  output logic         alu_start,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [1:0]   op_sel,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] disp_value,
  output logic         busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

  logic       key_evt;
  logic [3:0] key_code;

  key_event_qual #(.STABLE_CYC(STABLE_CYC)) u_qual (
    .clk         (clk),
    .reset       (reset),
    .btn_pressed (btn_pressed),
    .btn_out     (btn_out),
    .key_evt     (key_evt),
    .key_code    (key_code)
  );

  state_e        state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, disp_q, disp_d;
  logic [1:0]    op_sel_q, op_sel_d, pend_sel_q, pend_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          after_op_q, after_op_d;  // 1: continue to S_OP after exec, 0: S_RES
  logic          clr_pend_q, clr_pend_d;
  logic          start_q, start_d;

  logic          k_dig, k_op, k_eq, k_clr, do_clear;
  logic [W-1:0]  dval;

  function automatic logic [W-1:0] mul10(input logic [W-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

  always_comb begin
    k_dig = key_evt && is_digit(key_code);
    k_op  = key_evt && is_op(key_code);
    k_eq  = key_evt && (key_code == K_EQ);
    k_clr = key_evt && (key_code == K_CLR);
    dval  = {{(W-4){1'b0}}, key_code};

    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    pend_sel_d = pend_sel_q;
    cnt_d      = cnt_q;
    after_op_d = after_op_q;
    clr_pend_d = clr_pend_q;
    start_d    = 1'b0;
    do_clear   = 1'b0;

    case (state_q)
      S_A: begin
        if (k_clr) do_clear = 1'b1;
        else if (k_dig && (cnt_q < MAXD)) begin
          op_a_d = mul10(op_a_q) + dval;
          cnt_d  = cnt_q + CW'(1);
        end else if (k_op) begin
          op_sel_d = key_to_op(key_code);
          state_d  = S_OP;
        end
      end
      S_OP: begin
        if (k_clr) do_clear = 1'b1;
        else if (k_dig) begin
          op_b_d  = dval;
          cnt_d   = CW'(1);
          state_d = S_B;
        end else if (k_op) op_sel_d = key_to_op(key_code);
      end
      S_B: begin
        if (k_clr) do_clear = 1'b1;
        else if (k_dig && (cnt_q < MAXD)) begin
          op_b_d = mul10(op_b_q) + dval;
          cnt_d  = cnt_q + CW'(1);
        end else if (k_eq || k_op) begin
          // alu_start is registered, so it is high for the first S_EXEC cycle only.
          start_d    = 1'b1;
          state_d    = S_EXEC;
          after_op_d = k_op;
          clr_pend_d = 1'b0;
          if (k_op) pend_sel_d = key_to_op(key_code);
        end
      end
      S_EXEC: begin
        if (k_clr) clr_pend_d = 1'b1;
        if (alu_done) begin
          if (clr_pend_q || k_clr) do_clear = 1'b1;
          else begin
            op_a_d = alu_result;
            op_b_d = '0;
            cnt_d  = '0;
            if (after_op_q) begin
              op_sel_d = pend_sel_q;
              state_d  = S_OP;
            end else state_d = S_RES;
          end
        end
      end
      S_RES: begin
        if (k_clr) do_clear = 1'b1;
        else if (k_dig) begin
          op_a_d  = dval;
          cnt_d   = CW'(1);
          state_d = S_A;
        end else if (k_op) begin
          op_sel_d = key_to_op(key_code);
          state_d  = S_OP;
        end
      end
      default: do_clear = 1'b1;
    endcase

    if (do_clear) begin
      state_d    = S_A;
      op_a_d     = '0;
      op_b_d     = '0;
      op_sel_d   = OP_ADD;
      pend_sel_d = OP_ADD;
      cnt_d      = '0;
      after_op_d = 1'b0;
      clr_pend_d = 1'b0;
    end

    // Display follows the register state with one cycle of lag.
    disp_d = (state_q == S_B) ? op_b_q : op_a_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= OP_ADD;
      pend_sel_q <= OP_ADD;
      cnt_q      <= '0;
      after_op_q <= 1'b0;
      clr_pend_q <= 1'b0;
      start_q    <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      pend_sel_q <= pend_sel_d;
      cnt_q      <= cnt_d;
      after_op_q <= after_op_d;
      clr_pend_q <= clr_pend_d;
      start_q    <= start_d;
      disp_q     <= disp_d;
    end
  end

  assign alu_start  = start_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_sel     = op_sel_q;
  assign disp_value = disp_q;
  assign busy       = (state_q == S_EXEC);

endmodule

// File: tb/tb_calc_entry_fsm.sv
module tb_calc_entry_fsm;
  import calc_pkg::*;

  localparam int W  = 16;
  localparam int SC = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_pressed = 1'b0;
  logic [3:0]   btn_out = 4'h0;
  logic         alu_start;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   op_sel;
  logic         alu_done = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic [W-1:0] disp_value;
  logic         busy;

  calc_entry_fsm #(.W(W), .MAX_DIGITS(4), .STABLE_CYC(SC)) dut (
    .clk(clk), .reset(reset), .btn_pressed(btn_pressed), .btn_out(btn_out),
    .alu_start(alu_start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .alu_done(alu_done), .alu_result(alu_result), .disp_value(disp_value), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
  } start_t;

  start_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int evt_cnt = 0;
  logic [3:0] last_code = 4'h0;
  int alu_lat = 3;
  bit stray_req = 1'b0;

  // Scoreboard on alu_start plus a behavioural ALU answering after alu_lat cycles.
  task automatic mon_alu();
    int pend = 0;
    logic [W-1:0] res = '0;
    start_t e;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (reset) pend = 0;
      if (dut.key_evt) begin
        evt_cnt++;
        last_code = dut.key_code;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_done = 1'b1;
          alu_result = res;
        end
      end
      if (stray_req) begin
        alu_done = 1'b1;
        alu_result = 16'hBEEF;
        stray_req = 1'b0;
      end
      if (alu_start) begin
        start_cnt++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_start: got a=%0d b=%0d sel=%0d, none expected", op_a, op_b, op_sel);
        end else begin
          e = exp_q.pop_front();
          if ({op_a, op_b, op_sel} !== {e.a, e.b, e.sel}) begin
            n_fail++;
            $display("FAIL start_operands: got a=%0d b=%0d sel=%0d, want a=%0d b=%0d sel=%0d",
                     op_a, op_b, op_sel, e.a, e.b, e.sel);
          end
        end
        case (op_sel)
          OP_ADD:  res = op_a + op_b;
          OP_SUB:  res = op_a - op_b;
          OP_MUL:  res = op_a * op_b;
          default: res = (op_b == 0) ? '1 : op_a / op_b;
        endcase
        pend = alu_lat;
      end
    end
  endtask

  task automatic press(input logic [3:0] k);
    btn_pressed = 1'b1;
    btn_out = k;
    repeat (SC + 8) @(negedge clk);
    btn_pressed = 1'b0;
    repeat (SC + 8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_pressed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SC + 8) @(negedge clk);
  endtask

  task automatic chk_sb_empty(input string name);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_start: %0d expected starts never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({alu_start, op_a, op_b, op_sel, disp_value, busy} !== '0 || dut.state_q !== S_A) begin
      n_fail++;
      $display("FAIL reset_state: start=%0b a=%0d b=%0d sel=%0d disp=%0d busy=%0b, want all 0 in S_A",
               alu_start, op_a, op_b, op_sel, disp_value, busy);
    end
  endtask

  task automatic test_basic_add();
    int s0;
    do_reset();
    s0 = start_cnt;
    press(4'h1); press(4'h2); press(K_ADD); press(4'h3);
    exp_q.push_back('{a: 16'd12, b: 16'd3, sel: OP_ADD});
    press(K_EQ);
    n_assert++;
    if (start_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL add_start_count: got %0d, want 1", start_cnt - s0);
    end
    n_assert++;
    if (disp_value !== 16'd15 || op_a !== 16'd15) begin
      n_fail++;
      $display("FAIL add_result: disp=%0d op_a=%0d, want 15", disp_value, op_a);
    end
    n_assert++;
    if (dut.state_q !== S_RES) begin
      n_fail++;
      $display("FAIL add_state: got %0d, want S_RES", dut.state_q);
    end
    chk_sb_empty("add");
  endtask

  task automatic test_debounce();
    int e0;
    do_reset();
    e0 = evt_cnt;
    btn_pressed = 1'b1;
    btn_out = 4'h8;
    repeat (10) @(negedge clk);
    btn_out = 4'h7;
    repeat (190) @(negedge clk);
    btn_pressed = 1'b0;
    repeat (10) @(negedge clk);
    btn_pressed = 1'b1;
    repeat (60) @(negedge clk);
    btn_pressed = 1'b0;
    repeat (SC + 8) @(negedge clk);
    n_assert++;
    if (evt_cnt - e0 != 1 || last_code !== 4'h7) begin
      n_fail++;
      $display("FAIL debounce_events: got %0d events last code %0h, want 1 event code 7", evt_cnt - e0, last_code);
    end
    n_assert++;
    if (op_a !== 16'd7) begin
      n_fail++;
      $display("FAIL debounce_op_a: got %0d, want 7", op_a);
    end
  endtask

  task automatic test_digit_limit();
    do_reset();
    repeat (5) press(4'h9);
    n_assert++;
    if (op_a !== 16'd9999) begin
      n_fail++;
      $display("FAIL digit_limit: got %0d, want 9999", op_a);
    end
    press(K_CLR);
    n_assert++;
    if (op_a !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_in_a: got %0d, want 0", op_a);
    end
    press(4'h0); press(4'h0); press(4'h5);
    n_assert++;
    if (op_a !== 16'd5 || dut.cnt_q !== 3'd3) begin
      n_fail++;
      $display("FAIL leading_zero: op_a=%0d cnt=%0d, want 5 and 3", op_a, dut.cnt_q);
    end
    press(4'h7); press(4'h8);
    n_assert++;
    if (op_a !== 16'd57) begin
      n_fail++;
      $display("FAIL leading_zero_limit: got %0d, want 57", op_a);
    end
  endtask

  task automatic test_chain();
    do_reset();
    press(4'h5); press(K_MUL); press(4'h4);
    exp_q.push_back('{a: 16'd5, b: 16'd4, sel: OP_MUL});
    press(K_SUB);
    n_assert++;
    if (dut.state_q !== S_OP || op_a !== 16'd20 || op_sel !== OP_SUB) begin
      n_fail++;
      $display("FAIL chain_mid: state=%0d a=%0d sel=%0d, want S_OP 20 1", dut.state_q, op_a, op_sel);
    end
    press(4'h2);
    exp_q.push_back('{a: 16'd20, b: 16'd2, sel: OP_SUB});
    press(K_EQ);
    n_assert++;
    if (disp_value !== 16'd18) begin
      n_fail++;
      $display("FAIL chain_result: got %0d, want 18", disp_value);
    end
    chk_sb_empty("chain");
  endtask

  task automatic test_clear_in_exec();
    do_reset();
    alu_lat = 200;
    press(4'h6); press(K_ADD); press(4'h7);
    exp_q.push_back('{a: 16'd6, b: 16'd7, sel: OP_ADD});
    press(K_EQ);
    press(K_CLR);
    n_assert++;
    if (busy !== 1'b1 || op_a !== 16'd6) begin
      n_fail++;
      $display("FAIL exec_hold: busy=%0b op_a=%0d, want 1 and 6", busy, op_a);
    end
    repeat (150) @(negedge clk);
    n_assert++;
    if (dut.state_q !== S_A || op_a !== 16'd0 || disp_value !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after_done: state=%0d a=%0d disp=%0d busy=%0b, want S_A 0 0 0",
               dut.state_q, op_a, disp_value, busy);
    end
    alu_lat = 3;
    press(4'h3);
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++;
    if (dut.state_q !== S_A || op_a !== 16'd3 || op_b !== 16'd0) begin
      n_fail++;
      $display("FAIL stray_done: state=%0d a=%0d b=%0d, want S_A 3 0", dut.state_q, op_a, op_b);
    end
    chk_sb_empty("clear");
  endtask

  task automatic test_reset_in_b();
    do_reset();
    press(4'h1); press(K_ADD); press(4'h4); press(4'h2);
    n_assert++;
    if (op_b !== 16'd42 || disp_value !== 16'd42 || dut.state_q !== S_B) begin
      n_fail++;
      $display("FAIL b_entry: b=%0d disp=%0d state=%0d, want 42 42 S_B", op_b, disp_value, dut.state_q);
    end
    reset = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({alu_start, op_a, op_b, op_sel, disp_value, busy} !== '0 || dut.state_q !== S_A) begin
      n_fail++;
      $display("FAIL reset_in_b: start=%0b a=%0d b=%0d sel=%0d disp=%0d busy=%0b, want all 0",
               alu_start, op_a, op_b, op_sel, disp_value, busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      mon_alu();
    join_none
    test_reset();
    test_basic_add();
    test_debounce();
    test_digit_limit();
    test_chain();
    test_clear_in_exec();
    test_reset_in_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
